// File: rtl/store_buffer.sv
// Circular store buffer between MEM and the D-cache: holds stores until the ROB
// commits them, drains committed stores in order, and forwards data to loads.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif

module store_buffer #(
  parameter int N               = 4,
  parameter int WORD_SIZE       = `WORD_SIZE,
  parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid,
  input  logic [WORD_SIZE-1:0]       alloc_addr,
  input  logic [WORD_SIZE-1:0]       alloc_data,
  input  logic                       alloc_byte,
  input  logic [ROB_ENTRY_WIDTH-1:0] alloc_rob_id,
  output logic                       full,
  output logic                       empty,
  input  logic                       sb_store_permission,
  input  logic [ROB_ENTRY_WIDTH-1:0] sb_rob_id,
  input  logic                       flush,
  input  logic                       ld_valid,
  input  logic [WORD_SIZE-1:0]       ld_addr,
  input  logic                       ld_byte,
  output logic                       fwd_hit,
  output logic [WORD_SIZE-1:0]       fwd_data,
  output logic                       fwd_stall,
  output logic                       dc_req,
  output logic [WORD_SIZE-1:0]       dc_addr,
  output logic [WORD_SIZE-1:0]       dc_data,
  output logic                       dc_byte,
  input  logic                       dc_ack
);

  localparam int PTR_W = $clog2(N);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_INVALID   = 2'd0,
    ST_PENDING   = 2'd1,
    ST_COMMITTED = 2'd2
  } ent_state_t;

  ent_state_t                 state_q [N];
  ent_state_t                 state_d [N];
  logic [WORD_SIZE-1:0]       addr_q  [N];
  logic [WORD_SIZE-1:0]       data_q  [N];
  logic                       byte_q  [N];
  logic [ROB_ENTRY_WIDTH-1:0] rob_q   [N];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, n_comm;
  logic             pop, alloc_fire, perm_done;

  assign full       = (count_q == CNT_W'(N));
  assign empty      = (count_q == '0);
  assign dc_req     = (state_q[head_q] == ST_COMMITTED);
  assign dc_addr    = addr_q[head_q];
  assign dc_data    = data_q[head_q];
  assign dc_byte    = byte_q[head_q];
  assign pop        = dc_req && dc_ack;
  assign alloc_fire = alloc_valid && !full && !flush;

  // Next entry state: permission first, then flush or alloc, with pop always honoured
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    n_comm    = '0;
    perm_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sb_store_permission && !perm_done && state_q[i] == ST_PENDING &&
          rob_q[i] == sb_rob_id) begin
        state_d[i] = ST_COMMITTED;
        perm_done  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (state_d[i] == ST_COMMITTED) n_comm = n_comm + CNT_W'(1);
    end
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        if (state_d[i] == ST_PENDING) state_d[i] = ST_INVALID;
      end
      tail_d  = head_q + n_comm[PTR_W-1:0];
      count_d = n_comm - CNT_W'(pop);
    end else begin
      if (alloc_fire) begin
        state_d[tail_q] = ST_PENDING;
        tail_d          = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(pop);
    end
    if (pop) begin
      state_d[head_q] = ST_INVALID;
      head_d          = head_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '{default: ST_INVALID};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; validity lives entirely in state_q
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      addr_q[tail_q] <= alloc_addr;
      data_q[tail_q] <= alloc_data;
      byte_q[tail_q] <= alloc_byte;
      rob_q[tail_q]  <= alloc_rob_id;
    end
  end

  logic [3:0]       ld_mask, st_mask;
  logic [PTR_W-1:0] idx;
  logic [7:0]       sel_byte;
  logic             found;

  // Youngest-first scan: the first entry touching any load byte decides the result
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    found     = 1'b0;
    idx       = '0;
    st_mask   = '0;
    sel_byte  = '0;
    ld_mask   = ld_byte ? (4'b0001 << ld_addr[1:0]) : 4'b1111;
    for (int i = N - 1; i >= 0; i--) begin
      idx     = head_q + i[PTR_W-1:0];
      st_mask = byte_q[idx] ? (4'b0001 << addr_q[idx][1:0]) : 4'b1111;
      if (ld_valid && !found && state_q[idx] != ST_INVALID &&
          addr_q[idx][WORD_SIZE-1:2] == ld_addr[WORD_SIZE-1:2] &&
          |(st_mask & ld_mask)) begin
        found = 1'b1;
        if ((st_mask & ld_mask) == ld_mask) begin
          fwd_hit = 1'b1;
          if (ld_byte) begin
            sel_byte = byte_q[idx] ? data_q[idx][7:0]
                                   : data_q[idx][{ld_addr[1:0], 3'b000} +: 8];
            fwd_data = WORD_SIZE'(sel_byte);
          end else begin
            fwd_data = data_q[idx];
          end
        end else begin
          fwd_stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store_buffer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [31:0] alloc_addr, alloc_data;
  logic        alloc_byte;
  logic [3:0]  alloc_rob_id;
  logic        full, empty;
  logic        sb_store_permission;
  logic [3:0]  sb_rob_id;
  logic        flush;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_byte;
  logic        fwd_hit, fwd_stall;
  logic [31:0] fwd_data;
  logic        dc_req;
  logic [31:0] dc_addr, dc_data;
  logic        dc_byte;
  logic        dc_ack;

  store_buffer #(.N(N), .WORD_SIZE(32), .ROB_ENTRY_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_data(alloc_data),
    .alloc_byte(alloc_byte), .alloc_rob_id(alloc_rob_id),
    .full(full), .empty(empty),
    .sb_store_permission(sb_store_permission), .sb_rob_id(sb_rob_id),
    .flush(flush),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_byte(ld_byte),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_data(dc_data), .dc_byte(dc_byte),
    .dc_ack(dc_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          byte_st;
    logic [3:0]  rob;
    bit          comm;
  } ent_t;

  ent_t        q[$];
  bit          model_live = 0;
  int          vectors = 0;
  int          errs = 0;
  logic [3:0]  next_rob = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit covers(ent_t e, logic [31:0] a);
    if (e.byte_st) return a == e.addr;
    return a[31:2] == e.addr[31:2];
  endfunction

  function automatic logic [7:0] byte_of(ent_t e, logic [31:0] a);
    logic [31:0] off;
    if (e.byte_st) return e.data[7:0];
    off = a - {e.addr[31:2], 2'b00};
    return 8'(e.data >> (8 * off));
  endfunction

  // Byte-address view of forwarding: count how many load bytes the youngest touching store supplies
  task automatic model_fwd(output bit hit, output bit stall, output logic [31:0] d);
    int          need, ov;
    bit          done;
    logic [31:0] base, la, v;
    hit = 0; stall = 0; d = '0; done = 0;
    need = ld_byte ? 1 : 4;
    base = ld_byte ? ld_addr : {ld_addr[31:2], 2'b00};
    if (ld_valid) begin
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (!done) begin
          ov = 0; v = '0;
          for (int j = 0; j < need; j++) begin
            la = base + 32'(j);
            if (covers(q[k], la)) begin
              ov++;
              v = v | (32'(byte_of(q[k], la)) << (8 * j));
            end
          end
          if (ov > 0) begin
            done = 1;
            if (ov == need) begin hit = 1; d = v; end
            else stall = 1;
          end
        end
      end
    end
  endtask

  task automatic compare();
    bit          h, s, mreq;
    logic [31:0] d;
    model_fwd(h, s, d);
    mreq = (q.size() > 0) && q[0].comm;
    chk("full", 32'(full), 32'(q.size() == N));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("dc_req", 32'(dc_req), 32'(mreq));
    if (mreq) begin
      chk("dc_addr", dc_addr, q[0].addr);
      chk("dc_byte", 32'(dc_byte), 32'(q[0].byte_st));
      if (q[0].byte_st) chk("dc_data_b", 32'(dc_data[7:0]), 32'(q[0].data[7:0]));
      else              chk("dc_data", dc_data, q[0].data);
    end
    chk("fwd_hit", 32'(fwd_hit), 32'(h));
    chk("fwd_stall", 32'(fwd_stall), 32'(s));
    chk("fwd_data", fwd_data, d);
  endtask

  task automatic advance();
    bit   was_full, pop, done;
    ent_t e;
    ent_t nq[$];
    if (rst) begin
      q.delete();
      model_live = 1;
    end else begin
      was_full = (q.size() == N);
      pop = (q.size() > 0) && q[0].comm && dc_ack;
      done = 0;
      if (sb_store_permission) begin
        foreach (q[k]) begin
          if (!done && !q[k].comm && q[k].rob == sb_rob_id) begin
            q[k].comm = 1;
            done = 1;
          end
        end
      end
      if (flush) begin
        foreach (q[k]) if (q[k].comm) nq.push_back(q[k]);
        q = nq;
        if (pop) void'(q.pop_front());
      end else begin
        if (pop) void'(q.pop_front());
        if (alloc_valid && !was_full) begin
          e.addr = alloc_addr; e.data = alloc_data; e.byte_st = alloc_byte;
          e.rob = alloc_rob_id; e.comm = 0;
          q.push_back(e);
          next_rob = next_rob + 4'd1;
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    if (model_live) compare();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; alloc_valid = 0; alloc_addr = '0; alloc_data = '0; alloc_byte = 0;
    alloc_rob_id = '0; sb_store_permission = 0; sb_rob_id = '0; flush = 0;
    ld_valid = 0; ld_addr = '0; ld_byte = 0; dc_ack = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); idle();
  endtask

  task automatic alloc(input logic [31:0] a, input logic [31:0] d, input bit b, input logic [3:0] r);
    idle(); alloc_valid = 1; alloc_addr = a; alloc_data = d; alloc_byte = b; alloc_rob_id = r;
  endtask

  task automatic perm(input logic [3:0] r);
    idle(); sb_store_permission = 1; sb_rob_id = r;
  endtask

  initial begin
    idle(); rst = 1;
    tick();

    // reset state
    idle(); ld_valid = 1; ld_addr = 32'h100; #1;
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_dc_req", 32'(dc_req), 0);
    chk("rst_hit", 32'(fwd_hit), 0);
    chk("rst_stall", 32'(fwd_stall), 0);
    chk("rst_fdata", fwd_data, 0);
    tick();

    // commit then drain with held ack
    alloc(32'h100, 32'hDEADBEEF, 0, 4'd3); ld_valid = 1; ld_addr = 32'h100; #1;
    chk("same_cyc_invisible", 32'(fwd_hit), 0);
    tick();
    perm(4'd3); ld_valid = 1; ld_addr = 32'h100; #1;
    chk("pending_no_req", 32'(dc_req), 0);
    chk("next_cyc_visible", fwd_data, 32'hDEADBEEF);
    tick();
    for (int c = 0; c < 4; c++) begin
      idle(); #1;
      chk("hold_req", 32'(dc_req), 1);
      chk("hold_addr", dc_addr, 32'h100);
      chk("hold_data", dc_data, 32'hDEADBEEF);
      if (c == 3) dc_ack = 1;
      tick();
    end
    idle(); #1;
    chk("drained_empty", 32'(empty), 1);
    chk("drained_req", 32'(dc_req), 0);
    tick();

    // fill, reject while full, pop-with-alloc, in-order drain
    do_reset();
    for (int k = 0; k < 4; k++) begin
      alloc(32'h300 + 32'(4 * k), 32'hA0 + 32'(k), 0, 4'(4 + k)); tick();
    end
    idle(); #1; chk("fill_full", 32'(full), 1); tick();
    alloc(32'h340, 32'hBAD, 0, 4'd9); tick();
    perm(4'd4); tick();
    perm(4'd5); tick();
    alloc(32'h340, 32'hBAD, 0, 4'd9); dc_ack = 1; #1;
    chk("pop0_addr", dc_addr, 32'h300);
    tick();
    alloc(32'h350, 32'hB5, 0, 4'd10); dc_ack = 1; #1;
    chk("pop1_addr", dc_addr, 32'h304);
    chk("pop1_full", 32'(full), 0);
    tick();
    perm(4'd6); tick();
    perm(4'd7); tick();
    perm(4'd10); tick();
    begin
      logic [31:0] order [3];
      order[0] = 32'h308; order[1] = 32'h30C; order[2] = 32'h350;
      for (int k = 0; k < 3; k++) begin
        idle(); dc_ack = 1; #1;
        chk("order_req", 32'(dc_req), 1);
        chk("order_addr", dc_addr, order[k]);
        tick();
      end
    end
    idle(); #1; chk("order_empty", 32'(empty), 1); tick();

    // forwarding byte/word combinations
    do_reset();
    alloc(32'h200, 32'h11223344, 0, 4'd1); tick();
    alloc(32'h201, 32'h000000AA, 1, 4'd2); tick();
    idle(); ld_valid = 1; ld_byte = 1; ld_addr = 32'h201; #1;
    chk("fwd_b201_hit", 32'(fwd_hit), 1);
    chk("fwd_b201", fwd_data, 32'h000000AA);
    ld_addr = 32'h202; #1;
    chk("fwd_b202_hit", 32'(fwd_hit), 1);
    chk("fwd_b202", fwd_data, 32'h00000022);
    ld_byte = 0; ld_addr = 32'h200; #1;
    chk("fwd_w200_stall", 32'(fwd_stall), 1);
    chk("fwd_w200_hit", 32'(fwd_hit), 0);
    ld_byte = 1; ld_addr = 32'h208; #1;
    chk("fwd_miss", 32'(fwd_hit | fwd_stall), 0);
    tick();

    // flush keeps committed, drops pending and same-cycle alloc
    do_reset();
    alloc(32'h400, 32'h1, 0, 4'd1); tick();
    alloc(32'h404, 32'h2, 0, 4'd2); tick();
    alloc(32'h408, 32'h3, 0, 4'd3); sb_store_permission = 1; sb_rob_id = 4'd1; tick();
    alloc(32'h500, 32'h5, 0, 4'd5); flush = 1; tick();
    idle(); ld_valid = 1; ld_addr = 32'h404; dc_ack = 1; #1;
    chk("flush_req", 32'(dc_req), 1);
    chk("flush_addr", dc_addr, 32'h400);
    chk("flush_pending_gone", 32'(fwd_hit), 0);
    tick();
    idle(); ld_valid = 1; ld_addr = 32'h500; #1;
    chk("flush_empty", 32'(empty), 1);
    chk("flush_alloc_dropped", 32'(fwd_hit), 0);
    tick();

    // reset mid-drain
    do_reset();
    alloc(32'h600, 32'h66, 0, 4'd1); tick();
    alloc(32'h604, 32'h67, 0, 4'd2); tick();
    perm(4'd1); tick();
    idle(); #1; chk("middrain_req", 32'(dc_req), 1);
    rst = 1; tick();
    idle(); ld_valid = 1; ld_addr = 32'h600; #1;
    chk("middrain_empty", 32'(empty), 1);
    chk("middrain_req0", 32'(dc_req), 0);
    chk("middrain_nohit", 32'(fwd_hit), 0);
    tick();

    // randomized traffic
    do_reset();
    next_rob = 0;
    for (int c = 0; c < 3000; c++) begin
      int pend;
      idle();
      rst = ($urandom_range(0, 199) == 0);
      alloc_valid = $urandom_range(0, 1);
      alloc_byte = $urandom_range(0, 1);
      alloc_addr = 32'h100 + 32'($urandom_range(0, 15));
      if (!alloc_byte) alloc_addr[1:0] = 2'b00;
      alloc_data = $urandom;
      alloc_rob_id = next_rob;
      pend = -1;
      foreach (q[k]) if (pend < 0 && !q[k].comm) pend = k;
      if ($urandom_range(0, 9) < 4) begin
        sb_store_permission = 1;
        if (pend >= 0 && $urandom_range(0, 4) != 0) sb_rob_id = q[pend].rob;
        else sb_rob_id = next_rob + 4'd8;
      end
      flush = ($urandom_range(0, 29) == 0);
      dc_ack = $urandom_range(0, 1);
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_byte = $urandom_range(0, 1);
      ld_addr = 32'h100 + 32'($urandom_range(0, 15));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
